// File: rtl/sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder: MMIO window
// base, register offsets and the byte-lane merge used by RAM and registers.
package sram_resp_pkg;

  localparam logic [15:0] MMIO_BASE  = 16'hBFAF;
  localparam logic [15:0] TIMER_OFF  = 16'hE000;
  localparam logic [15:0] LED_OFF    = 16'hF020;
  localparam logic [15:0] SWITCH_OFF = 16'hF030;
  localparam logic [15:0] NUM_OFF    = 16'hF050;

  // Lane i of the result comes from new_word when we[i] is set, else old_word.
  function automatic logic [31:0] byte_merge(input logic [3:0]  we,
                                             input logic [31:0] old_word,
                                             input logic [31:0] new_word);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mmio_regs.sv
// Memory-mapped register block: free-running timer, LED and numeric-display
// registers, two-flop switch synchronizer and the MMIO read mux.
module mmio_regs
  import sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [3:0]  we,
  input  logic [15:0] off,
  input  logic [31:0] wdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output logic [31:0] rd_data
);

  logic [31:0] timer_q, timer_d, timer_inc_s;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  // Next-state for the timer (increment, written lanes override), LED and NUM.
  always_comb begin
    timer_inc_s = timer_q + 32'd1;
    timer_d     = timer_inc_s;
    led_d       = led_q;
    num_d       = num_q;
    if (wr_en && (off == TIMER_OFF)) begin
      timer_d = byte_merge(we, timer_inc_s, wdata);
    end else begin
      timer_d = timer_inc_s;
    end
    if (wr_en && (off == LED_OFF)) begin
      // Only lanes 0-1 exist; lanes 2-3 of the write are discarded.
      led_d[7:0]  = we[0] ? wdata[7:0]  : led_q[7:0];
      led_d[15:8] = we[1] ? wdata[15:8] : led_q[15:8];
    end else begin
      led_d = led_q;
    end
    if (wr_en && (off == NUM_OFF)) begin
      num_d = byte_merge(we, num_q, wdata);
    end else begin
      num_d = num_q;
    end
  end

  // Register state and switch synchronizer, cleared by async reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q   <= 32'h0000_0000;
      led_q     <= 16'h0000;
      num_q     <= 32'h0000_0000;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      timer_q   <= timer_d;
      led_q     <= led_d;
      num_q     <= num_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Read mux: TIMER returns the pre-increment value; unmapped offsets read 0.
  always_comb begin
    rd_data = 32'h0000_0000;
    case (off)
      TIMER_OFF:  rd_data = timer_q;
      LED_OFF:    rd_data = {16'h0000, led_q};
      SWITCH_OFF: rd_data = {24'h00_0000, sw_sync_q};
      NUM_OFF:    rd_data = num_q;
      default:    rd_data = 32'h0000_0000;
    endcase
  end

  assign led      = led_q;
  assign num_data = num_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM port responder: word-addressed RAM plus MMIO window, returning
// read data one cycle after the request through a holding rdata register.
module data_sram_resp
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       ram_q [DEPTH];
  logic              is_mmio_s, rd_s, wr_s, mmio_wr_s, ram_wr_s;
  logic [ADDR_W-1:0] ram_idx_s;
  logic [31:0]       mmio_rd_s;
  logic [31:0]       rdata_q, rdata_d;

  // Request decode: MMIO window by upper half-word, RAM index aliases above ADDR_W.
  always_comb begin
    is_mmio_s = (data_sram_addr[31:16] == MMIO_BASE);
    ram_idx_s = data_sram_addr[ADDR_W+1:2];
    rd_s      = data_sram_en && (data_sram_we == 4'b0000);
    wr_s      = data_sram_en && (data_sram_we != 4'b0000);
    mmio_wr_s = wr_s && is_mmio_s;
    ram_wr_s  = wr_s && !is_mmio_s;
  end

  mmio_regs u_mmio (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (mmio_wr_s),
    .we       (data_sram_we),
    .off      (data_sram_addr[15:0]),
    .wdata    (data_sram_wdata),
    .switch   (switch),
    .led      (led),
    .num_data (num_data),
    .rd_data  (mmio_rd_s)
  );

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      ram_q[ram_idx_s] <= byte_merge(data_sram_we, ram_q[ram_idx_s], data_sram_wdata);
    end
  end

  // Read data select: reads load a new word, writes and idles hold the old one.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_s) begin
      if (is_mmio_s) begin
        rdata_d = mmio_rd_s;
      end else begin
        rdata_d = ram_q[ram_idx_s];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register; an in-flight request is dropped by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'h0000_0000;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;

endmodule
